// File: rtl/cpu_trace_pkg.sv
// cpu_trace_pkg: shared state/cause encodings and record-width helper for the
// CPU trace monitor.
package cpu_trace_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } mon_state_t;

   typedef enum logic [1:0] {
      HC_NONE    = 2'd0,
      HC_TIMEOUT = 2'd1,
      HC_HALT    = 2'd2,
      HC_STOP    = 2'd3
   } halt_cause_t;

   // Width of one trace record: {timestamp, pc, channels}.
   function automatic int REC_W(input int cnt_w, input int pc_w,
                                input int nch, input int data_w);
      return cnt_w + pc_w + nch * data_w;
   endfunction

endpackage

// File: rtl/trace_fifo.sv
// trace_fifo: first-word fall-through FIFO for trace records. The head word is
// visible on dout whenever the FIFO is non-empty; dout reads zero when empty.
// A push into a full FIFO is accepted only if a pop happens in the same cycle.
module trace_fifo #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    flush,
   input  logic                    push,
   input  logic [WIDTH-1:0]        din,
   output logic                    full,
   input  logic                    pop,
   output logic [WIDTH-1:0]        dout,
   output logic                    empty,
   output logic [$clog2(DEPTH):0]  count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_LVL = DEPTH[AW:0];

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count == '0);
   assign full    = (count == FULL_LVL);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign dout    = empty ? '0 : mem[rd_ptr];

   // Pointer and level bookkeeping; flush discards contents like a reset.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Storage array; not reset, empty masking keeps dout clean.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/cpu_trace_monitor.sv
// cpu_trace_monitor: samples committed PC and debug channels during a run,
// buffers timestamped records in a FWFT FIFO, and ends the run on stop,
// a halt loop (repeated identical PC) or a cycle timeout.
module cpu_trace_monitor
   import cpu_trace_pkg::*;
#(
   parameter int PC_W        = 32,
   parameter int DATA_W      = 32,
   parameter int NCH         = 2,
   parameter int DEPTH       = 16,
   parameter int CNT_W       = 32,
   parameter int MAX_CYCLES  = 1000000000,
   parameter int HALT_REPEAT = 4
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic                                start,
   input  logic                                commit_valid,
   input  logic [PC_W-1:0]                     debug_pc,
   input  logic [NCH*DATA_W-1:0]               debug_rf_data,
   input  logic                                only_on_change,
   output logic                                trace_valid,
   input  logic                                trace_ready,
   output logic [CNT_W+PC_W+NCH*DATA_W-1:0]    trace_data,
   output logic                                running,
   output logic                                done,
   output logic [1:0]                          halt_cause,
   input  logic                                stop,
   output logic                                overflow,
   output logic [15:0]                         drop_count
);

   localparam int RW    = REC_W(CNT_W, PC_W, NCH, DATA_W);
   localparam int RPT_W = (HALT_REPEAT < 2) ? 2 : $clog2(HALT_REPEAT + 1);

   mon_state_t                  state;
   halt_cause_t                 cause_q;
   logic [CNT_W-1:0]            cyc_cnt;
   logic [PC_W-1:0]             prev_pc;
   logic [RPT_W-1:0]            rpt_cnt;
   logic [RPT_W-1:0]            rpt_nxt;
   logic [NCH-1:0][DATA_W-1:0]  cur_ch;
   logic [NCH-1:0][DATA_W-1:0]  last_ch;
   logic [NCH-1:0]              ch_diff;
   logic                        seen_rec;

   logic                        is_run;
   logic                        commit;
   logic                        rec_req;
   logic                        pop;
   logic                        drop;
   logic                        flush;
   logic                        stop_hit;
   logic                        halt_hit;
   logic                        tmo_hit;

   logic                        fifo_full;
   logic                        fifo_empty;
   logic [$clog2(DEPTH):0]      fifo_lvl_unused;
   logic [RW-1:0]               rec_word;

   assign cur_ch = debug_rf_data;

   // Per-channel change detect against the last recorded values.
   genvar k;
   generate
      for (k = 0; k < NCH; k++) begin : g_ch
         assign ch_diff[k] = (cur_ch[k] != last_ch[k]);
      end
   endgenerate

   assign is_run  = (state == ST_RUN);
   assign commit  = commit_valid && is_run;
   // First commit of a run always records, even in change-only mode.
   assign rec_req = commit && (!only_on_change || !seen_rec || (|ch_diff));

   // Length of the current streak of identical committed PCs (saturating).
   // A cleared count on run entry makes the first commit yield 1 regardless
   // of the stale prev_pc.
   assign rpt_nxt = (debug_pc == prev_pc) ?
                    ((rpt_cnt == '1) ? rpt_cnt : rpt_cnt + 1'b1) :
                    RPT_W'(1);

   assign stop_hit = is_run && stop;
   assign halt_hit = (HALT_REPEAT != 0) && commit && (rpt_nxt == RPT_W'(HALT_REPEAT));
   assign tmo_hit  = (MAX_CYCLES != 0) && is_run && (cyc_cnt == CNT_W'(MAX_CYCLES - 1));

   assign trace_valid = !fifo_empty;
   assign pop         = trace_valid && trace_ready;
   assign drop        = rec_req && fifo_full && !pop;
   assign flush       = start && !is_run;
   assign rec_word    = {cyc_cnt, debug_pc, debug_rf_data};
   assign halt_cause  = cause_q;

   // Run FSM with registered status outputs, counters and filter state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_IDLE;
         running    <= 1'b0;
         done       <= 1'b0;
         cause_q    <= HC_NONE;
         cyc_cnt    <= '0;
         prev_pc    <= '0;
         rpt_cnt    <= '0;
         last_ch    <= '0;
         seen_rec   <= 1'b0;
         overflow   <= 1'b0;
         drop_count <= '0;
      end else begin
         case (state)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  state      <= ST_RUN;
                  running    <= 1'b1;
                  done       <= 1'b0;
                  cause_q    <= HC_NONE;
                  cyc_cnt    <= '0;
                  rpt_cnt    <= '0;
                  last_ch    <= '0;
                  seen_rec   <= 1'b0;
                  overflow   <= 1'b0;
                  drop_count <= '0;
               end
            end
            ST_RUN: begin
               cyc_cnt <= cyc_cnt + 1'b1;
               if (commit) begin
                  rpt_cnt <= rpt_nxt;
                  prev_pc <= debug_pc;
               end
               if (rec_req) begin
                  last_ch  <= cur_ch;
                  seen_rec <= 1'b1;
               end
               if (drop) begin
                  overflow <= 1'b1;
                  if (drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
               end
               if (stop_hit || halt_hit || tmo_hit) begin
                  state   <= ST_DONE;
                  running <= 1'b0;
                  done    <= 1'b1;
                  if (stop_hit)      cause_q <= HC_STOP;
                  else if (halt_hit) cause_q <= HC_HALT;
                  else               cause_q <= HC_TIMEOUT;
               end
            end
            default: begin
               state   <= ST_IDLE;
               running <= 1'b0;
               done    <= 1'b0;
            end
         endcase
      end
   end

   // Record buffer; level output is a debug tap not needed here.
   trace_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (RW)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .flush (flush),
      .push  (rec_req),
      .din   (rec_word),
      .full  (fifo_full),
      .pop   (pop),
      .dout  (trace_data),
      .empty (fifo_empty),
      .count (fifo_lvl_unused)
   );

endmodule

// File: tb/tb_cpu_trace_monitor.sv
// tb_cpu_trace_monitor: directed scenarios followed by randomized traffic,
// every cycle compared against a queue-based behavioural model.
module tb_cpu_trace_monitor;

   localparam int PC_W        = 16;
   localparam int DATA_W      = 16;
   localparam int NCH         = 2;
   localparam int DEPTH       = 4;
   localparam int CNT_W       = 16;
   localparam int MAX_CYCLES  = 40;
   localparam int HALT_REPEAT = 4;
   localparam int RW          = CNT_W + PC_W + NCH * DATA_W;

   logic                  clk;
   logic                  rst;
   logic                  start;
   logic                  commit_valid;
   logic [PC_W-1:0]       debug_pc;
   logic [NCH*DATA_W-1:0] debug_rf_data;
   logic                  only_on_change;
   logic                  trace_valid;
   logic                  trace_ready;
   logic [RW-1:0]         trace_data;
   logic                  running;
   logic                  done;
   logic [1:0]            halt_cause;
   logic                  stop;
   logic                  overflow;
   logic [15:0]           drop_count;

   cpu_trace_monitor #(
      .PC_W(PC_W), .DATA_W(DATA_W), .NCH(NCH), .DEPTH(DEPTH), .CNT_W(CNT_W),
      .MAX_CYCLES(MAX_CYCLES), .HALT_REPEAT(HALT_REPEAT)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .commit_valid(commit_valid),
      .debug_pc(debug_pc), .debug_rf_data(debug_rf_data),
      .only_on_change(only_on_change), .trace_valid(trace_valid),
      .trace_ready(trace_ready), .trace_data(trace_data), .running(running),
      .done(done), .halt_cause(halt_cause), .stop(stop), .overflow(overflow),
      .drop_count(drop_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   // Behavioural model: run flag, queue of records, simple counters.
   logic [RW-1:0]         m_q[$];
   bit                    m_run, m_done, m_ovf, m_first;
   logic [1:0]            m_cause;
   logic [15:0]           m_drop;
   logic [CNT_W-1:0]      m_cnt;
   int                    m_rep;
   logic [PC_W-1:0]       m_pc;
   logic [NCH*DATA_W-1:0] m_last;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      assert (got === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic model_step();
      bit hlt, tmo, rec;
      if (rst) begin
         m_run = 0; m_done = 0; m_cause = 0; m_ovf = 0; m_drop = 0;
         m_cnt = '0; m_rep = 0; m_q.delete();
         return;
      end
      if (m_q.size() > 0 && trace_ready) void'(m_q.pop_front());
      if (!m_run) begin
         if (start) begin
            m_q.delete();
            m_run = 1; m_done = 0; m_cause = 0; m_ovf = 0; m_drop = 0;
            m_cnt = '0; m_rep = 0; m_first = 1; m_last = '0;
         end
         return;
      end
      hlt = 0;
      if (commit_valid) begin
         m_rep = (m_rep > 0 && debug_pc == m_pc) ? m_rep + 1 : 1;
         m_pc  = debug_pc;
         hlt   = (HALT_REPEAT != 0) && (m_rep == HALT_REPEAT);
         rec   = !only_on_change || m_first || (debug_rf_data != m_last);
         if (rec) begin
            m_first = 0;
            m_last  = debug_rf_data;
            if (m_q.size() < DEPTH) m_q.push_back({m_cnt, debug_pc, debug_rf_data});
            else begin
               m_ovf = 1;
               if (m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
            end
         end
      end
      tmo = (m_cnt == CNT_W'(MAX_CYCLES - 1));
      if (stop)      m_cause = 2'd3;
      else if (hlt)  m_cause = 2'd2;
      else if (tmo)  m_cause = 2'd1;
      if (stop || hlt || tmo) begin m_run = 0; m_done = 1; end
      m_cnt = m_cnt + 1'b1;
   endtask

   task automatic check_all();
      logic [RW-1:0] exp_d;
      exp_d = (m_q.size() > 0) ? m_q[0] : '0;
      chk("trace_valid", 64'(trace_valid), 64'(m_q.size() > 0));
      chk("trace_data",  64'(trace_data),  64'(exp_d));
      chk("running",     64'(running),     64'(m_run));
      chk("done",        64'(done),        64'(m_done));
      chk("halt_cause",  64'(halt_cause),  64'(m_cause));
      chk("overflow",    64'(overflow),    64'(m_ovf));
      chk("drop_count",  64'(drop_count),  64'(m_drop));
   endtask

   // One clock: model advances on the current inputs, DUT checked mid-low phase.
   task automatic cycle();
      model_step();
      @(posedge clk);
      @(negedge clk);
      check_all();
   endtask

   function automatic logic [CNT_W-1:0] f_ts(input logic [RW-1:0] d);
      return d[NCH*DATA_W+PC_W +: CNT_W];
   endfunction
   function automatic logic [PC_W-1:0] f_pc(input logic [RW-1:0] d);
      return d[NCH*DATA_W +: PC_W];
   endfunction

   task automatic do_commit(input logic [PC_W-1:0] pc, input logic [DATA_W-1:0] ch0);
      commit_valid = 1; debug_pc = pc; debug_rf_data = {16'h0, ch0};
      cycle();
      commit_valid = 0;
   endtask

   int nrec;
   logic [PC_W-1:0] exp_pc [4];

   initial begin
      rst = 1; start = 0; stop = 0; commit_valid = 0; debug_pc = '0;
      debug_rf_data = '0; only_on_change = 0; trace_ready = 1;
      @(negedge clk);
      cycle();
      chk("rst_valid", 64'(trace_valid), 64'd0);
      chk("rst_data",  64'(trace_data),  64'd0);
      rst = 0;
      cycle();

      // Three commits, timestamps 0,1,2, each visible the cycle after commit.
      start = 1; cycle(); start = 0;
      chk("start_running", 64'(running), 64'd1);
      do_commit(16'h0, 16'h11);
      chk("t1_valid0", 64'(trace_valid), 64'd1);
      chk("t1_ts0", 64'(f_ts(trace_data)), 64'd0);
      do_commit(16'h4, 16'h12);
      chk("t1_ts1", 64'(f_ts(trace_data)), 64'd1);
      chk("t1_pc1", 64'(f_pc(trace_data)), 64'h4);
      do_commit(16'h8, 16'h13);
      chk("t1_ts2", 64'(f_ts(trace_data)), 64'd2);
      chk("t1_pc2", 64'(f_pc(trace_data)), 64'h8);
      cycle();
      stop = 1; cycle(); stop = 0;
      chk("stop_cause", 64'(halt_cause), 64'd3);

      // Halt loop: 4 commits at 0x40, all recorded.
      trace_ready = 0;
      start = 1; cycle(); start = 0;
      for (int i = 0; i < 4; i++) do_commit(16'h40, 16'(i));
      chk("halt_done",  64'(done), 64'd1);
      chk("halt_cause", 64'(halt_cause), 64'd2);
      trace_ready = 1;
      nrec = 0;
      for (int i = 0; i < 6; i++) begin
         if (trace_valid) nrec++;
         cycle();
      end
      chk("halt_records", 64'(nrec), 64'd4);

      // Timeout with no commits.
      start = 1; cycle(); start = 0;
      for (int i = 0; i < MAX_CYCLES - 1; i++) cycle();
      chk("tmo_still_run", 64'(running), 64'd1);
      cycle();
      chk("tmo_done",  64'(done), 64'd1);
      chk("tmo_cause", 64'(halt_cause), 64'd1);
      chk("tmo_valid", 64'(trace_valid), 64'd0);

      // Overflow: 6 commits into a depth-4 FIFO with no drain.
      trace_ready = 0;
      start = 1; cycle(); start = 0;
      for (int i = 0; i < 6; i++) do_commit(16'(16'h100 + 4 * i), 16'(i));
      chk("ovf_flag", 64'(overflow), 64'd1);
      chk("ovf_drops", 64'(drop_count), 64'd2);
      chk("ovf_head", 64'(f_pc(trace_data)), 64'h100);

      // Full FIFO, pop and push in the same cycle: push accepted.
      trace_ready = 1;
      do_commit(16'h200, 16'h9);
      chk("fullpop_drops", 64'(drop_count), 64'd2);
      exp_pc[0] = 16'h104; exp_pc[1] = 16'h108; exp_pc[2] = 16'h10c; exp_pc[3] = 16'h200;
      for (int i = 0; i < 4; i++) begin
         chk("drain_valid", 64'(trace_valid), 64'd1);
         chk("drain_pc", 64'(f_pc(trace_data)), 64'(exp_pc[i]));
         cycle();
      end
      chk("drain_empty", 64'(trace_valid), 64'd0);
      stop = 1; cycle(); stop = 0;

      // Change-only mode: data 5,5,7 gives two records, then reset mid-run.
      only_on_change = 1;
      start = 1; cycle(); start = 0;
      do_commit(16'h300, 16'd5);
      chk("ooc_v1", 64'(trace_valid), 64'd1);
      chk("ooc_d1", 64'(trace_data[DATA_W-1:0]), 64'd5);
      do_commit(16'h304, 16'd5);
      chk("ooc_v2", 64'(trace_valid), 64'd0);
      do_commit(16'h308, 16'd7);
      chk("ooc_v3", 64'(trace_valid), 64'd1);
      chk("ooc_d3", 64'(trace_data[DATA_W-1:0]), 64'd7);
      trace_ready = 0;
      rst = 1; cycle(); rst = 0;
      chk("mrst_running", 64'(running), 64'd0);
      chk("mrst_valid",   64'(trace_valid), 64'd0);
      chk("mrst_data",    64'(trace_data), 64'd0);
      only_on_change = 0;

      // Randomized traffic.
      for (int i = 0; i < 1500; i++) begin
         rst            = ($urandom_range(0, 299) == 0);
         start          = ($urandom_range(0, 3) == 0);
         stop           = ($urandom_range(0, 59) == 0);
         commit_valid   = ($urandom_range(0, 1) == 1);
         debug_pc       = 16'($urandom_range(0, 2) * 4);
         debug_rf_data  = {16'($urandom_range(0, 2)), 16'($urandom_range(0, 2))};
         only_on_change = ($urandom_range(0, 1) == 1);
         trace_ready    = ($urandom_range(0, 2) != 0);
         cycle();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/cpu_trace_monitor.md
# cpu_trace_monitor

Synthesizable run monitor for the pipelined CPU. It replaces the fixed-length, file-dumping simulation loop with a parametrised hardware block. The block samples the committed PC and up to NCH debug register channels, and buffers timestamped trace records in an internal FIFO for a downstream drain (UART, bench, or ILA). It ends the run on a timeout or a detected halt loop. It sits beside the CPU top, on the `debug_pc` / `debug_rf_data` buses.

## Interface
- PC_W, 32, PC width
- DATA_W, 32, width of one debug data channel
- NCH, 2, number of sampled data channels (1..4)
- DEPTH, 16, trace FIFO depth (power of two, ≥2)
- CNT_W, 32, cycle-counter / timestamp width
- MAX_CYCLES, 1000000000, timeout in cycles (0 = no timeout)
- HALT_REPEAT, 4, consecutive identical committed PCs that declare a halt (0 = disabled)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset; one clock; reset is synchronous and active-high
- start  in  1  pulse: begin a run (ignored unless state is IDLE or DONE)
- commit_valid  in  1  CPU committed an instruction this cycle
- debug_pc  in  PC_W  PC of the committed instruction
- debug_rf_data  in  NCH*DATA_W  packed channel data; channel k at [k*DATA_W +: DATA_W]
- only_on_change  in  1  mode: 1 = record only when any channel differs from the last recorded values
- trace_valid  out  1  FIFO head valid
- trace_ready  in  1  drain accepts head
- trace_data  out  CNT_W+PC_W+NCH*DATA_W  {timestamp, pc, channels}
- running  out  1  state RUN
- done  out  1  state DONE
- halt_cause  out  2  0 none, 1 timeout, 2 halt loop, 3 external stop
- stop  in  1  pulse: force end of run
- overflow  out  1  sticky: at least one record dropped this run
- drop_count  out  16  dropped records, saturating at 16'hFFFF

## Operation
- States: IDLE → RUN on `start`. RUN → DONE on timeout, halt loop, or `stop`. DONE → RUN on `start`. `rst` forces IDLE from any state.
- Entering RUN clears:
  - the cycle counter, overflow, drop_count, halt_cause, the repeat counter and the last-recorded channel registers;
  - the FIFO contents.
- In RUN the cycle counter increments every clock. Timeout fires when counter == MAX_CYCLES-1. The counter does not wrap before timeout. With MAX_CYCLES=0 it wraps modulo 2^CNT_W.
- Record candidate: commit_valid in RUN. With only_on_change=1, the first commit of a run always records.
- Record format: timestamp = cycle counter value in the commit cycle.
- Halt detection: the repeat counter increments when commit_valid and debug_pc equals the previous committed PC. Otherwise it resets to 1 on a commit. Halt fires when the count reaches HALT_REPEAT, and that commit is still recorded.
- Priority when several end causes coincide: stop > halt loop > timeout. The record of the ending cycle is still pushed.
- Full FIFO and no simultaneous pop: the record is dropped, overflow is set and drop_count increments.
- Full FIFO with a pop in the same cycle: the push is accepted.
- The FIFO continues draining in DONE and IDLE. No pushes occur outside RUN.

## Timing
- Reset values:
  - trace_valid=0, trace_data=0;
  - running=0, done=0, halt_cause=0;
  - overflow=0, drop_count=0.
- Record latency: a commit in cycle N appears at the FIFO head (empty FIFO) with trace_valid=1 in cycle N+1. The FIFO is first-word fall-through.
- Handshake: a transfer occurs when trace_valid && trace_ready. trace_data is held stable while valid && !ready.
- `start` in cycle N: running=1 from N+1. The first timestamp is 0 for a commit in cycle N+1.
- End event in cycle N: running=0, done=1 and halt_cause valid from N+1.
- rst mid-run: all outputs reach reset values on the next edge and FIFO contents are discarded.

## Structure
- Package `cpu_trace_pkg`:
  - state encoding (IDLE/RUN/DONE);
  - halt_cause codes;
  - record-width localparam function REC_W(CNT_W,PC_W,NCH,DATA_W).
- Sub-module `trace_fifo` (DEPTH, WIDTH):
  - FWFT, synchronous active-high reset;
  - push/full/pop/empty, count of log2(DEPTH)+1 bits.
- The top holds the FSM, counters, halt detector and change filter.

## Test plan
- Reset, then start, then 3 commits at PC 0x0, 0x4, 0x8 with ready=1. Expect 3 records with timestamps 0, 1, 2. Each appears one cycle after its commit.
- HALT_REPEAT=4, commits at PC 0x40 in 4 consecutive cycles. Expect done the cycle after the 4th commit, halt_cause=2, and 4 records.
- MAX_CYCLES=10, no commits. Expect done at the cycle after counter=9, halt_cause=1, trace_valid=0.
- DEPTH=4, ready=0, 6 commits. Expect 4 records kept, overflow=1 and drop_count=2. Then assert ready and drain 4 records in order.
- FIFO full, with ready=1 and a commit in the same cycle. Expect the push accepted, count stays 4 and drop_count unchanged.
- only_on_change=1, channel 0 data 5,5,7 on 3 commits. Expect 2 records (data 5, 7). Then assert rst mid-run and expect all outputs at reset values the next cycle.
